// File: rtl/jts16_tile_rom_arb.sv
// Tile-ROM read arbiter: char and two scroll layers share one SDRAM slot.
// Char has fixed priority; the scroll layers alternate on ties.
module jts16_tile_rom_arb #(
  parameter int            AW        = 22,
  parameter logic [AW-1:0] CHAR_BASE = '0,
  parameter logic [AW-1:0] SCR_BASE  = AW'(22'h4000),
  parameter int            TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          char_cs,
  input  logic [13:0]   char_addr,
  output logic          char_ok,
  output logic [15:0]   char_data,
  input  logic          scr1_cs,
  input  logic [16:0]   scr1_addr,
  output logic          scr1_ok,
  output logic [15:0]   scr1_data,
  input  logic          scr2_cs,
  input  logic [16:0]   scr2_addr,
  output logic          scr2_ok,
  output logic [15:0]   scr2_data,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_data,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } st_t;

  st_t           st;
  logic [2:0]    pend;
  logic [2:0]    okv;
  logic [2:0]    csd;
  logic [2:0]    win;
  logic          rr;
  logic [13:0]   char_last;
  logic [16:0]   scr1_last;
  logic [16:0]   scr2_last;
  logic [CW-1:0] cnt;

  logic [2:0]    cs_v;
  logic [2:0]    hit;
  logic [2:0]    set_v;
  logic [2:0]    gnt;
  logic [2:0]    pend_n;
  logic [2:0]    ok_n;
  logic [AW-1:0] gnt_addr;
  logic          acc;
  logic          acc_ok;
  logic          tmo;

  assign cs_v  = {scr2_cs, scr1_cs, char_cs};
  assign hit   = {scr2_addr == scr2_last,
                  scr1_addr == scr1_last,
                  char_addr == char_last};
  assign set_v = cs_v & (~csd | ~hit);

  assign acc    = (st == WAIT) && sdram_rdy;
  assign acc_ok = acc && |(win & cs_v & hit);
  assign tmo    = (st == WAIT) && !sdram_rdy
                  && (cnt == TLAST);

  assign char_ok = okv[0];
  assign scr1_ok = okv[1];
  assign scr2_ok = okv[2];

  // rr=1 means scr2 won last, so scr1 takes the next tie
  always_comb begin
    gnt[0] = pend[0];
    gnt[1] = !pend[0] && pend[1]
             && (!pend[2] || rr);
    gnt[2] = !pend[0] && pend[2]
             && (!pend[1] || !rr);
  end

  always_comb begin
    gnt_addr = '0;
    unique case (1'b1)
      gnt[0]:  gnt_addr = CHAR_BASE + AW'(char_addr);
      gnt[1]:  gnt_addr = SCR_BASE + AW'(scr1_addr);
      gnt[2]:  gnt_addr = SCR_BASE + AW'(scr2_addr);
      default: gnt_addr = '0;
    endcase
  end

  always_comb begin
    pend_n = (pend | set_v) & cs_v;
    ok_n   = okv & cs_v & ~set_v;
    if (st == IDLE)
      pend_n = pend_n & ~gnt;
    if (tmo)
      pend_n = pend_n | (win & cs_v);
    if (acc_ok)
      ok_n = ok_n | (win & cs_v & hit & ~set_v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      pend        <= '0;
      okv         <= '0;
      csd         <= '0;
      win         <= '0;
      rr          <= 1'b1;
      char_last   <= '0;
      scr1_last   <= '0;
      scr2_last   <= '0;
      cnt         <= '0;
      char_data   <= '0;
      scr1_data   <= '0;
      scr2_data   <= '0;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      timeout_err <= 1'b0;
    end else begin
      pend <= pend_n;
      okv  <= ok_n;
      csd  <= cs_v;
      if (acc_ok) begin
        if (win[0]) char_data <= sdram_data;
        if (win[1]) scr1_data <= sdram_data;
        if (win[2]) scr2_data <= sdram_data;
      end
      unique case (st)
        IDLE: begin
          if (|gnt) begin
            st         <= REQ;
            win        <= gnt;
            sdram_req  <= 1'b1;
            sdram_addr <= gnt_addr;
            if (gnt[0]) char_last <= char_addr;
            if (gnt[1]) begin
              scr1_last <= scr1_addr;
              rr        <= 1'b0;
            end
            if (gnt[2]) begin
              scr2_last <= scr2_addr;
              rr        <= 1'b1;
            end
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            st        <= WAIT;
            cnt       <= '0;
          end
        end
        WAIT: begin
          if (sdram_rdy) begin
            st <= IDLE;
          end else if (cnt == TLAST) begin
            st          <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
